frame_scanout: RTL and testbench

FRAME_SCANOUT -- requirements
Module: frame_scanout

---
 rtl/frame_scanout_if.sv | 28 ++
 rtl/frame_scanout.sv | 188 ++++++++++++++++++
 tb/tb_frame_scanout.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/frame_scanout_if.sv
// Frame-buffer read port and bank-swap handshake between the scan-out engine
// (master) and the frame-buffer / rasterizer side (slave).
interface frame_scanout_if;
    logic        rd_en;
    logic [16:0] rd_addr;
    logic [3:0]  rd_data;
    logic        fb_front;
    logic        swap_req;
    logic        swap_ack;

    modport master (
        output rd_en,
        output rd_addr,
        output fb_front,
        output swap_ack,
        input  rd_data,
        input  swap_req
    );

    modport slave (
        input  rd_en,
        input  rd_addr,
        input  fb_front,
        input  swap_ack,
        output rd_data,
        output swap_req
    );
endinterface

// File: rtl/frame_scanout.sv
// VGA scan-out engine for a half-resolution, double-buffered frame buffer.
// Pixel counters advance every second clock. Each visible pixel is fetched on
// its pix_tick clock, and the colour reaches the pins two clocks later,
// aligned with the delayed syncs. Bank swaps happen only at end of frame.
// Build option: define FRAME_SCANOUT_RGBI_EN to map the 4-bit pixel index as
// RGBI. Without it the index drives all three channels as grayscale.
module frame_scanout #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int FB_WIDTH = 320
) (
    input  logic                  vga_clk,
    input  logic                  reset,
    frame_scanout_if.master       fb,
    output logic                  frame_start,
    output logic                  vga_hs,
    output logic                  vga_vs,
    output logic [3:0]            vga_r,
    output logic [3:0]            vga_g,
    output logic [3:0]            vga_b
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL + 1);
    localparam int VW      = $clog2(V_TOTAL + 1);

    localparam logic [HW-1:0] H_LAST       = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT        = HW'(H_ACTIVE);
    localparam logic [HW-1:0] H_SYNC_START = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] H_SYNC_END   = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW-1:0] V_LAST       = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT        = VW'(V_ACTIVE);
    localparam logic [VW-1:0] V_ACT_LAST   = VW'(V_ACTIVE - 1);
    localparam logic [VW-1:0] V_SYNC_START = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] V_SYNC_END   = VW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [16:0]   FB_STEP      = 17'(FB_WIDTH);

    typedef enum logic {
        S_IDLE,
        S_WAIT_LOW
    } swap_state_t;

    logic            pix_tick;
    logic [HW-1:0]   h_cnt;
    logic [VW-1:0]   v_cnt;
    logic [16:0]     row_base;
    logic            active;
    logic            raw_hs;
    logic            raw_vs;
    logic            h_wrap;
    logic            eof;
    logic            fetch_next;
    logic            rd_en_q;
    logic [16:0]     rd_addr_q;
    logic            hs_d1;
    logic            vs_d1;
    logic            act_d1;
    logic            front_q;
    logic            ack_q;
    swap_state_t     swap_state;

    // Colour lookup for one frame-buffer pixel index.
    function automatic logic [11:0] map_colour(input logic [3:0] idx);
`ifdef FRAME_SCANOUT_RGBI_EN
        logic [3:0] lvl;
        lvl = idx[3] ? 4'hF : 4'h8;
        return {idx[2] ? lvl : 4'h0, idx[1] ? lvl : 4'h0, idx[0] ? lvl : 4'h0};
`else
        return {idx, idx, idx};
`endif
    endfunction

    assign active     = (h_cnt < H_ACT) && (v_cnt < V_ACT);
    assign raw_hs     = !((h_cnt >= H_SYNC_START) && (h_cnt < H_SYNC_END));
    assign raw_vs     = !((v_cnt >= V_SYNC_START) && (v_cnt < V_SYNC_END));
    assign h_wrap     = pix_tick && (h_cnt == H_LAST);
    assign eof        = h_wrap && (v_cnt == V_ACT_LAST);
    // Counters hold across a non-tick clock, so the coming tick sees the same position.
    assign fetch_next = !pix_tick && active;

    assign fb.rd_en    = rd_en_q;
    assign fb.rd_addr  = rd_addr_q;
    assign fb.fb_front = front_q;
    assign fb.swap_ack = ack_q;

    // Divide the 50 MHz clock down to a 25 MHz pixel enable.
    always_ff @(posedge vga_clk) begin
        if (reset) begin
            pix_tick <= 1'b0;
        end else begin
            pix_tick <= !pix_tick;
        end
    end

    // Raster position plus the frame-buffer row base, kept as a running sum of FB_WIDTH.
    always_ff @(posedge vga_clk) begin
        if (reset) begin
            h_cnt    <= '0;
            v_cnt    <= '0;
            row_base <= '0;
        end else if (pix_tick) begin
            if (h_cnt == H_LAST) begin
                h_cnt <= '0;
                if (v_cnt == V_LAST) begin
                    v_cnt    <= '0;
                    row_base <= '0;
                end else begin
                    v_cnt <= v_cnt + VW'(1);
                    if (v_cnt[0]) begin
                        row_base <= row_base + FB_STEP;
                    end
                end
            end else begin
                h_cnt <= h_cnt + HW'(1);
            end
        end
    end

    // Registered fetch strobe, address and frame marker, timed to land on the tick clock.
    always_ff @(posedge vga_clk) begin
        if (reset) begin
            rd_en_q     <= 1'b0;
            rd_addr_q   <= '0;
            frame_start <= 1'b0;
        end else begin
            rd_en_q <= fetch_next;
            if (fetch_next) begin
                rd_addr_q <= row_base + 17'(h_cnt >> 1);
            end
            frame_start <= !pix_tick && (h_cnt == '0) && (v_cnt == '0);
        end
    end

    // Two-stage sync/active delay matching the one-clock RAM latency plus the colour register.
    always_ff @(posedge vga_clk) begin
        if (reset) begin
            hs_d1  <= 1'b1;
            vs_d1  <= 1'b1;
            act_d1 <= 1'b0;
            vga_hs <= 1'b1;
            vga_vs <= 1'b1;
            {vga_r, vga_g, vga_b} <= 12'h000;
        end else begin
            hs_d1  <= raw_hs;
            vs_d1  <= raw_vs;
            act_d1 <= active;
            vga_hs <= hs_d1;
            vga_vs <= vs_d1;
            {vga_r, vga_g, vga_b} <= act_d1 ? map_colour(fb.rd_data) : 12'h000;
        end
    end

    // Bank-swap handshake: swap only at end of frame, then wait for the request to drop.
    always_ff @(posedge vga_clk) begin
        if (reset) begin
            swap_state <= S_IDLE;
            front_q    <= 1'b0;
            ack_q      <= 1'b0;
        end else begin
            ack_q <= 1'b0;
            case (swap_state)
                S_IDLE: begin
                    if (eof && fb.swap_req) begin
                        front_q    <= !front_q;
                        ack_q      <= 1'b1;
                        swap_state <= S_WAIT_LOW;
                    end
                end
                S_WAIT_LOW: begin
                    if (!fb.swap_req) begin
                        swap_state <= S_IDLE;
                    end
                end
                default: begin
                    swap_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_frame_scanout.sv
// Testbench for frame_scanout on a reduced raster (24x12 pixel ticks per frame)
// so that many frames fit in a short run. Expected behaviour is derived from the
// clock count since reset: position = count/2, fetches on odd counts.
module tb_frame_scanout;

    localparam int HA  = 16;
    localparam int HFP = 2;
    localparam int HSW = 4;
    localparam int HBP = 2;
    localparam int VA  = 8;
    localparam int VFP = 1;
    localparam int VSW = 2;
    localparam int VBP = 1;
    localparam int FBW = 8;
    localparam int HT  = HA + HFP + HSW + HBP;
    localparam int VT  = VA + VFP + VSW + VBP;
    localparam int LINE_CLKS  = 2 * HT;
    localparam int FRAME_CLKS = 2 * HT * VT;

    logic       vga_clk = 1'b0;
    logic       reset;
    logic       frame_start;
    logic       vga_hs;
    logic       vga_vs;
    logic [3:0] vga_r;
    logic [3:0] vga_g;
    logic [3:0] vga_b;

    frame_scanout_if fb();

    frame_scanout #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
        .FB_WIDTH(FBW)
    ) dut (
        .vga_clk    (vga_clk),
        .reset      (reset),
        .fb         (fb),
        .frame_start(frame_start),
        .vga_hs     (vga_hs),
        .vga_vs     (vga_vs),
        .vga_r      (vga_r),
        .vga_g      (vga_g),
        .vga_b      (vga_b)
    );

    always #10 vga_clk = ~vga_clk;

    int          total = 0;
    int          bad   = 0;
    logic [3:0]  mem [0:255];
    int          n;
    bit          exp_front;
    bit          exp_ack;
    bit          seen_low;
    logic [16:0] exp_addr;
    logic        prev_en;
    logic [16:0] prev_addr;
    logic        hs_prev;
    logic        vs_prev;
    logic        front_prev;
    int          hs_fall;
    int          vs_fall;
    int          fs_last;
    int          line_period = -1;
    int          hs_low      = -1;
    int          vs_low      = -1;
    int          fs_period   = -1;
    int          max_addr    = -1;
    int          toggles     = 0;
    int          waited;
    bit          want_front;

    function automatic int h_at(int c);
        return (c / 2) % HT;
    endfunction

    function automatic int v_at(int c);
        return ((c / 2) / HT) % VT;
    endfunction

    function automatic bit act_at(int c);
        return (h_at(c) < HA) && (v_at(c) < VA);
    endfunction

    function automatic bit fetch_at(int c);
        return (c % 2 == 1) && act_at(c);
    endfunction

    function automatic int addr_at(int c);
        return (v_at(c) / 2) * FBW + h_at(c) / 2;
    endfunction

    function automatic bit eof_at(int c);
        return (c % 2 == 1) && (h_at(c) == HT - 1) && (v_at(c) == VA - 1);
    endfunction

    function automatic bit hs_at(int c);
        int h;
        if (c < 2) return 1'b1;
        h = h_at(c - 2);
        return !((h >= HA + HFP) && (h < HA + HFP + HSW));
    endfunction

    function automatic bit vs_at(int c);
        int v;
        if (c < 2) return 1'b1;
        v = v_at(c - 2);
        return !((v >= VA + VFP) && (v < VA + VFP + VSW));
    endfunction

    function automatic logic [11:0] colour(input logic [3:0] d);
`ifdef FRAME_SCANOUT_RGBI_EN
        logic [3:0] lvl;
        lvl = d[3] ? 4'hF : 4'h8;
        return {d[2] ? lvl : 4'h0, d[1] ? lvl : 4'h0, d[0] ? lvl : 4'h0};
`else
        return {d, d, d};
`endif
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s: got %0h want %0h at clock %0d", tag, obs, exp, n);
        end
    endtask

    task automatic checkOutput();
        if (fetch_at(n)) exp_addr = 17'(addr_at(n));
        check("rd_en", 32'(fb.rd_en), 32'(fetch_at(n)));
        check("rd_addr", 32'(fb.rd_addr), 32'(exp_addr));
        check("frame_start", 32'(frame_start),
              32'((n % 2 == 1) && (h_at(n) == 0) && (v_at(n) == 0)));
        check("vga_hs", 32'(vga_hs), 32'(hs_at(n)));
        check("vga_vs", 32'(vga_vs), 32'(vs_at(n)));
        check("fb_front", 32'(fb.fb_front), 32'(exp_front));
        check("swap_ack", 32'(fb.swap_ack), 32'(exp_ack));
        if (n < 2 || !act_at(n - 2)) begin
            check("rgb_blank", 32'({vga_r, vga_g, vga_b}), 32'(12'h000));
        end else if (fetch_at(n - 2)) begin
            check("rgb_pixel", 32'({vga_r, vga_g, vga_b}),
                  32'(colour(mem[8'(addr_at(n - 2))])));
        end
        if (hs_prev === 1'b1 && vga_hs === 1'b0) begin
            if (hs_fall >= 0) line_period = n - hs_fall;
            hs_fall = n;
        end
        if (hs_prev === 1'b0 && vga_hs === 1'b1 && hs_fall >= 0) hs_low = n - hs_fall;
        if (vs_prev === 1'b1 && vga_vs === 1'b0) vs_fall = n;
        if (vs_prev === 1'b0 && vga_vs === 1'b1 && vs_fall >= 0) vs_low = n - vs_fall;
        if (frame_start === 1'b1) begin
            if (fs_last >= 0) fs_period = n - fs_last;
            fs_last = n;
        end
        if (fb.rd_en === 1'b1 && int'(fb.rd_addr) > max_addr) max_addr = int'(fb.rd_addr);
        if (fb.fb_front !== front_prev) toggles++;
        hs_prev    = vga_hs;
        vs_prev    = vga_vs;
        front_prev = fb.fb_front;
    endtask

    task automatic applyStimulus(input bit req);
        bit front_next;
        bit ack_next;
        fb.swap_req = req;
        front_next  = exp_front;
        ack_next    = 1'b0;
        if (eof_at(n) && req && seen_low) begin
            front_next = !exp_front;
            ack_next   = 1'b1;
            seen_low   = 1'b0;
        end else if (!req) begin
            seen_low = 1'b1;
        end
        prev_en   = fb.rd_en;
        prev_addr = fb.rd_addr;
        @(posedge vga_clk);
        #1;
        n++;
        exp_front = front_next;
        exp_ack   = ack_next;
        if (prev_en === 1'b1) fb.rd_data = mem[prev_addr[7:0]];
        checkOutput();
    endtask

    task automatic doReset(input bit req);
        reset       = 1'b1;
        fb.swap_req = req;
        @(posedge vga_clk);
        #1;
        reset      = 1'b0;
        n          = 0;
        exp_front  = 1'b0;
        exp_ack    = 1'b0;
        seen_low   = 1'b1;
        exp_addr   = '0;
        hs_prev    = 1'b1;
        vs_prev    = 1'b1;
        front_prev = 1'b0;
        hs_fall    = -1;
        vs_fall    = -1;
        fs_last    = -1;
        check("rst_rd_en", 32'(fb.rd_en), 32'(0));
        check("rst_rd_addr", 32'(fb.rd_addr), 32'(0));
        check("rst_syncs", 32'({vga_hs, vga_vs}), 32'(2'b11));
        check("rst_rgb", 32'({vga_r, vga_g, vga_b}), 32'(0));
        check("rst_front_ack_fs", 32'({fb.fb_front, fb.swap_ack, frame_start}), 32'(0));
        checkOutput();
    endtask

    initial begin
        reset       = 1'b1;
        fb.swap_req = 1'b0;
        fb.rd_data  = 4'h0;
        n           = 0;
        for (int i = 0; i < 256; i++) mem[i] = 4'($urandom);
        repeat (3) @(posedge vga_clk);
        #1;
        $display("[TB] frame_scanout bench start");

        // Free-running raster with no swap request.
        doReset(1'b0);
        repeat (2 * FRAME_CLKS + 8) applyStimulus(1'b0);
        check("line_period", 32'(line_period), 32'(LINE_CLKS));
        check("hs_low_clks", 32'(hs_low), 32'(2 * HSW));
        check("vs_low_clks", 32'(vs_low), 32'(2 * VSW * HT));
        check("frame_period", 32'(fs_period), 32'(FRAME_CLKS));
        check("last_addr", 32'(max_addr), 32'((VA / 2) * FBW - 1));

        // Request held high from mid-frame: exactly one swap.
        repeat ($urandom_range(FRAME_CLKS / 4, FRAME_CLKS / 2)) applyStimulus(1'b0);
        toggles = 0;
        repeat (FRAME_CLKS * 5 / 2) applyStimulus(1'b1);
        check("held_req_swaps", 32'(toggles), 32'(1));

        // Drop, then raise again: one more swap at the next end of frame.
        repeat ($urandom_range(1, 10)) applyStimulus(1'b0);
        toggles = 0;
        repeat (FRAME_CLKS + 4) applyStimulus(1'b1);
        check("rearm_swaps", 32'(toggles), 32'(1));

        // Random request levels and durations.
        for (int s = 0; s < 12; s++) begin
            bit r;
            r = 1'($urandom_range(0, 1));
            repeat ($urandom_range(1, FRAME_CLKS)) applyStimulus(r);
        end

        // Request rising in the end-of-frame clock is honoured there.
        repeat (4) applyStimulus(1'b0);
        for (int k = 0; k < FRAME_CLKS && !eof_at(n); k++) applyStimulus(1'b0);
        want_front = !exp_front;
        applyStimulus(1'b1);
        check("eof_rise_front", 32'(fb.fb_front), 32'(want_front));
        check("eof_rise_ack", 32'(fb.swap_ack), 32'(1));
        repeat (6) applyStimulus(1'b1);
        repeat (6) applyStimulus(1'b0);

        // Request rising one clock after end of frame waits a full frame.
        for (int k = 0; k < FRAME_CLKS && !eof_at(n); k++) applyStimulus(1'b0);
        applyStimulus(1'b0);
        want_front = exp_front;
        waited = 0;
        while (fb.fb_front === want_front && waited < 2 * FRAME_CLKS) begin
            applyStimulus(1'b1);
            waited++;
        end
        check("late_rise_delay", 32'(waited), 32'(FRAME_CLKS));

        // Reset mid-line with the request still high.
        repeat ($urandom_range(LINE_CLKS, 3 * LINE_CLKS)) applyStimulus(1'b1);
        doReset(1'b1);
        waited = 0;
        while (fb.fb_front === 1'b0 && waited < 2 * FRAME_CLKS) begin
            applyStimulus(1'b1);
            waited++;
        end
        check("post_reset_swap_clock", 32'(n), 32'(2 * HT * VA));
        repeat (20) applyStimulus(1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
